afu_channel_arbiter: RTL
========================

Name: afu_channel_arbiter

Overview:
- Parametrised command front-end for the next-generation cached AFU.
- Replaces the fixed read/write/WED command triple with NUM_CHANNELS generic requester channels, each driven by one compute unit or the WED fetcher.
- Arbitrates channels onto the single PSL command port, tracks PSL command credits, allocates tags, and routes each response back to the channel that owns its tag.
- Sits between the compute-unit array and the command/buffer control block.

Parameters:
- NUM_CHANNELS, 4: number of requester channels (2..16).
- CMD_WIDTH, 96: width of the opaque command payload per channel (command code, address, size).
- TAG_WIDTH, 8: PSL tag width.
- MAX_OUTSTANDING, 32: outstanding-tag table depth; must be ≤ 2**TAG_WIDTH and a power of two.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enabled_in  in  1  job running; no grants when low.
- room_in  in  8  PSL initial credit count; sampled on the rising edge of enabled_in.
- req_valid  in  NUM_CHANNELS  per-channel request.
- req_command  in  NUM_CHANNELS*CMD_WIDTH  per-channel payload; channel i occupies slice i.
- req_ready  out  NUM_CHANNELS  one-hot grant; the request is accepted when req_valid[i] & req_ready[i].
- cmd_valid  out  1  command issued to the PSL.
- cmd_payload  out  CMD_WIDTH  granted payload.
- cmd_tag  out  TAG_WIDTH  allocated tag.
- resp_valid  in  1  PSL response strobe.
- resp_tag  in  TAG_WIDTH  response tag.
- resp_code  in  8  PSL response code.
- chan_resp_valid  out  NUM_CHANNELS  one-hot routed response.
- chan_resp_code  out  8  routed response code.
- credits  out  9  current credit count.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  number of tags in use.
- tag_error  out  1  sticky error flag.

Behaviour:
- Reset values:
  - req_ready, cmd_valid, chan_resp_valid, tag_error = 0.
  - cmd_payload, cmd_tag, chan_resp_code = 0.
  - credits = 0, outstanding = 0.
  - Tag table fully free; round-robin pointer = 0.
- Credit load: on the cycle enabled_in goes 0->1, credits <= room_in.
- Credit clear: on enabled_in 1->0, credits <= 0, the tag table is cleared and tag_error is held.
- Grant condition, combinational in cycle t: enabled_in & credits != 0 & a free tag exists & any req_valid. Exactly one req_ready bit is high. If the condition fails, req_ready = 0.
- Round-robin (ARB_MODE=0): search starts at pointer p. After a grant to channel g, p <= (g+1) mod NUM_CHANNELS. Pointer wraps from NUM_CHANNELS-1 to 0.
- Fixed priority (ARB_MODE=1): lowest-index valid channel wins; the pointer is ignored.
- Tag allocation: lowest-index free table entry e; cmd_tag = e zero-extended. Entry e records the owning channel and is marked busy.
- Issue latency: accept in cycle t -> cmd_valid = 1 for exactly one cycle at t+1, with payload and tag registered. Back-to-back grants every cycle are legal.
- Response latency: resp_valid in cycle t with a busy tag -> at t+1, chan_resp_valid[owner] = 1 and chan_resp_code = resp_code. At t+1 the entry is freed and credits is incremented.
- Freed tag and returned credit are usable by the arbiter from cycle t+1.
- Simultaneous grant and response in the same cycle: credits and outstanding are net unchanged. A grant may not take the tag being freed in that same cycle.
- Credits saturate at 255 and are never decremented below 0.
- Response carrying a tag ≥ MAX_OUTSTANDING, or a tag that is not busy: tag_error <= 1 (sticky until reset), no channel strobe, credits unchanged.
- Reset asserted mid-operation: all state returns to its reset value asynchronously. In-flight tags are abandoned and no chan_resp_valid is generated for them.

Decomposition:
- Shared package (AFU_PKG): ArbMode enum, tag-table entry typedef {busy, channel}, credit-width constant.
- One sub-module: afu_tag_table. It holds the busy bitmap and owner array, provides find-first-free, and handles allocate and free ports with same-cycle conflict resolution.
- The arbiter, credit counter and output registers stay in afu_channel_arbiter.

Test Plan:
- Reset values: assert reset mid-burst -> all outputs 0 within the same cycle. After release with room_in=64 and enabled rising -> credits=64.
- Round-robin fairness: NUM_CHANNELS=4, all req_valid held high, credits 64 -> grant order 0,1,2,3,0,1...; cmd_tag sequence 0,1,2,3...; cmd_valid continuous from cycle 2.
- Credit exhaustion: room_in=2, channel 1 requests continuously -> two grants then req_ready=0. A response with tag 0 -> chan_resp_valid=4'b0010 one cycle later, and the next grant reuses tag 0.
- Tag exhaustion: MAX_OUTSTANDING=32, room_in=64 -> 32 grants then stall with credits=32 and outstanding=32.
- Simultaneous response and grant at credits=1: credits stays 1, outstanding unchanged, the freed tag is not reissued in that cycle.
- Bogus response: resp_tag=40 (≥32) or an unused tag -> tag_error=1 sticky, no chan_resp_valid, credits unchanged.
- Fixed priority: ARB_MODE=1, channels 0 and 3 both valid -> channel 0 always wins and channel 3 starves until channel 0 drops req_valid.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared types and constants for the AFU command front-end: arbitration mode,
// tag-table entry layout and credit counter sizing.
package afu_pkg;

    typedef enum logic {
        ArbRoundRobin = 1'b0,
        ArbFixed      = 1'b1
    } arb_mode_e;

    // Wide enough for the largest supported channel count (16).
    localparam int unsigned ChanIdxWidth = 4;

    localparam int unsigned CreditWidth = 9;
    localparam int unsigned CreditMax   = 255;

    typedef struct packed {
        logic                    busy;
        logic [ChanIdxWidth-1:0] channel;
    } tag_entry_t;

endpackage

// File: rtl/afu_tag_table.sv
// Outstanding-tag table: busy/owner per entry, lowest-free search, allocate and
// release ports, and a count of entries in use.
module afu_tag_table
    import afu_pkg::*;
#(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      alloc,
    input  logic [ChanIdxWidth-1:0]   alloc_channel,
    output logic                      any_free,
    output logic [$clog2(DEPTH)-1:0]  free_index,
    input  logic                      release_valid,
    input  logic [TAG_WIDTH-1:0]      release_tag,
    output logic                      release_hit,
    output logic [ChanIdxWidth-1:0]   release_owner,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned IdxWidth = $clog2(DEPTH);

    tag_entry_t            table_q [DEPTH];
    tag_entry_t            table_d [DEPTH];
    logic [IdxWidth:0]     count_q;
    logic [IdxWidth:0]     count_d;
    logic [IdxWidth-1:0]   rel_idx;
    logic                  rel_in_range;

    assign rel_idx       = release_tag[IdxWidth-1:0];
    assign rel_in_range  = (release_tag >> IdxWidth) == '0;
    assign release_hit   = release_valid & rel_in_range & table_q[rel_idx].busy;
    assign release_owner = table_q[rel_idx].channel;
    assign count         = count_q;

    always_comb begin
        any_free   = 1'b0;
        free_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!table_q[i].busy) begin
                any_free   = 1'b1;
                free_index = IdxWidth'(i);
            end
        end
    end

    // The allocated entry comes from the registered free set while a release
    // needs a busy entry, so the two never collide; alloc is applied last.
    always_comb begin
        table_d = table_q;
        count_d = count_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_d[i] = '0;
            end
            count_d = '0;
        end else begin
            if (release_hit) begin
                table_d[rel_idx].busy = 1'b0;
            end
            if (alloc) begin
                table_d[free_index].busy    = 1'b1;
                table_d[free_index].channel = alloc_channel;
            end
            case ({alloc, release_hit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            table_q <= table_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/afu_channel_arbiter.sv
// Command front-end: arbitrates requester channels onto the PSL command port,
// tracks credits, allocates tags and routes responses back to their owners.
module afu_channel_arbiter
    import afu_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 4,
    parameter int unsigned CMD_WIDTH       = 96,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned MAX_OUTSTANDING = 32,
    parameter int unsigned ARB_MODE        = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enabled_in,
    input  logic [7:0]                         room_in,
    input  logic [NUM_CHANNELS-1:0]            req_valid,
    input  logic [NUM_CHANNELS*CMD_WIDTH-1:0]  req_command,
    output logic [NUM_CHANNELS-1:0]            req_ready,
    output logic                               cmd_valid,
    output logic [CMD_WIDTH-1:0]               cmd_payload,
    output logic [TAG_WIDTH-1:0]               cmd_tag,
    input  logic                               resp_valid,
    input  logic [TAG_WIDTH-1:0]               resp_tag,
    input  logic [7:0]                         resp_code,
    output logic [NUM_CHANNELS-1:0]            chan_resp_valid,
    output logic [7:0]                         chan_resp_code,
    output logic [CreditWidth-1:0]             credits,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               tag_error
);

    localparam int unsigned IdxWidth = $clog2(MAX_OUTSTANDING);
    localparam arb_mode_e   Mode     = (ARB_MODE == 0) ? ArbRoundRobin : ArbFixed;
    localparam logic [ChanIdxWidth:0]   NumChan   = (ChanIdxWidth + 1)'(NUM_CHANNELS);
    localparam logic [ChanIdxWidth-1:0] LastChan  = ChanIdxWidth'(NUM_CHANNELS - 1);
    localparam logic [CreditWidth-1:0]  CreditCap = CreditWidth'(CreditMax);

    logic                          enabled_q;
    logic                          rise;
    logic                          fall;
    logic [CreditWidth-1:0]        credits_q;
    logic [CreditWidth-1:0]        credits_d;
    logic [ChanIdxWidth-1:0]       rr_ptr_q;
    logic [ChanIdxWidth-1:0]       rr_ptr_d;

    logic [2*NUM_CHANNELS-1:0]     doubled;
    logic [NUM_CHANNELS-1:0]       rotated;
    logic [ChanIdxWidth-1:0]       offset;
    logic [ChanIdxWidth:0]         rr_sum;
    logic [ChanIdxWidth:0]         rr_wrap;
    logic [ChanIdxWidth-1:0]       grant_idx;
    logic                          grant_found;
    logic                          accept;
    logic [NUM_CHANNELS-1:0]       grant_onehot;
    logic [CMD_WIDTH-1:0]          grant_payload;

    logic                          any_free;
    logic [IdxWidth-1:0]           free_index;
    logic                          resp_hit;
    logic [ChanIdxWidth-1:0]       resp_owner;
    logic [NUM_CHANNELS-1:0]       resp_onehot;

    logic                          cmd_valid_q;
    logic [CMD_WIDTH-1:0]          cmd_payload_q;
    logic [TAG_WIDTH-1:0]          cmd_tag_q;
    logic [NUM_CHANNELS-1:0]       chan_resp_valid_q;
    logic [7:0]                    chan_resp_code_q;
    logic                          tag_error_q;

    assign rise = enabled_in & ~enabled_q;
    assign fall = ~enabled_in & enabled_q;

    afu_tag_table #(
        .DEPTH     (MAX_OUTSTANDING),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_table (
        .clock         (clock),
        .reset         (reset),
        .clear         (fall),
        .alloc         (accept),
        .alloc_channel (grant_idx),
        .any_free      (any_free),
        .free_index    (free_index),
        .release_valid (resp_valid),
        .release_tag   (resp_tag),
        .release_hit   (resp_hit),
        .release_owner (resp_owner),
        .count         (outstanding)
    );

    // Round-robin rotates the request vector so the pointer lands on bit 0,
    // finds the lowest set bit, then maps the offset back to a channel index.
    always_comb begin
        doubled     = {req_valid, req_valid} >> rr_ptr_q;
        rotated     = doubled[NUM_CHANNELS-1:0];
        offset      = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        rr_wrap     = '0;
        if (Mode == ArbFixed) begin
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = ChanIdxWidth'(i);
                end
            end
        end else begin
            for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
                if (rotated[k]) begin
                    grant_found = 1'b1;
                    offset      = ChanIdxWidth'(k);
                end
            end
            rr_sum  = {1'b0, rr_ptr_q} + {1'b0, offset};
            rr_wrap = rr_sum - NumChan;
            grant_idx = (rr_sum >= NumChan) ? rr_wrap[ChanIdxWidth-1:0]
                                            : rr_sum[ChanIdxWidth-1:0];
        end
    end

    assign accept = enabled_in & (credits_q != '0) & any_free & grant_found;

    always_comb begin
        grant_payload = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            grant_onehot[i] = accept & (grant_idx == ChanIdxWidth'(i));
            resp_onehot[i]  = resp_hit & (resp_owner == ChanIdxWidth'(i));
            if (grant_onehot[i]) begin
                grant_payload = req_command[i*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    assign req_ready = grant_onehot;

    always_comb begin
        credits_d = credits_q;
        if (rise) begin
            credits_d = CreditWidth'(room_in);
        end else if (fall) begin
            credits_d = '0;
        end else begin
            case ({accept, resp_hit})
                2'b10:   credits_d = credits_q - 1'b1;
                2'b01:   credits_d = (credits_q < CreditCap) ? credits_q + 1'b1 : CreditCap;
                default: credits_d = credits_q;
            endcase
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && Mode == ArbRoundRobin) begin
            rr_ptr_d = (grant_idx == LastChan) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enabled_q         <= 1'b0;
            credits_q         <= '0;
            rr_ptr_q          <= '0;
            cmd_valid_q       <= 1'b0;
            cmd_payload_q     <= '0;
            cmd_tag_q         <= '0;
            chan_resp_valid_q <= '0;
            chan_resp_code_q  <= '0;
            tag_error_q       <= 1'b0;
        end else begin
            enabled_q         <= enabled_in;
            credits_q         <= credits_d;
            rr_ptr_q          <= rr_ptr_d;
            cmd_valid_q       <= accept;
            chan_resp_valid_q <= resp_onehot;
            tag_error_q       <= tag_error_q | (resp_valid & ~resp_hit);
            if (accept) begin
                cmd_payload_q <= grant_payload;
                cmd_tag_q     <= TAG_WIDTH'(free_index);
            end
            if (resp_hit) begin
                chan_resp_code_q <= resp_code;
            end
        end
    end

    assign cmd_valid       = cmd_valid_q;
    assign cmd_payload     = cmd_payload_q;
    assign cmd_tag         = cmd_tag_q;
    assign chan_resp_valid = chan_resp_valid_q;
    assign chan_resp_code  = chan_resp_code_q;
    assign credits         = credits_q;
    assign tag_error       = tag_error_q;

endmodule
